poly_voice_controller: RTL and testbench

- Polyphonic successor to the single-note ALU controller.
- Accepts note-on/note-off events and allocates each note to one of NUM_VOICES voices.
- Each voice runs its own square-wave phase counter and a per-voice attack/sustain/release envelope.
- Voices are mixed into one registered sample, `wave_out`, which feeds the audio output path.

---
 rtl/poly_voice_if.sv | 26 ++
 rtl/poly_voice_controller.sv | 190 +++++++++++++++++++
 tb/tb_poly_voice_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/poly_voice_if.sv
// Note-event bus and mixed-output bundle for the polyphonic voice controller.
interface poly_voice_if #(
  parameter int NUM_VOICES = 4,
  parameter int AMP_W      = 6,
  parameter int FREQ_W     = 16
);
  logic                  note_on;
  logic                  note_off;
  logic [6:0]            key;
  logic [FREQ_W-1:0]     half_period;
  logic [AMP_W-1:0]      amplitude;
  logic [AMP_W-1:0]      attack;
  logic [AMP_W-1:0]      rel;
  logic [NUM_VOICES-1:0] voices_active;
  logic [AMP_W:0]        wave_out;

  modport master (
    output note_on, note_off, key, half_period, amplitude, attack, rel,
    input  voices_active, wave_out
  );

  modport slave (
    input  note_on, note_off, key, half_period, amplitude, attack, rel,
    output voices_active, wave_out
  );
endinterface

// File: rtl/poly_voice_controller.sv
// Polyphonic square-wave synth core: allocates notes to voices, runs a per-voice
// attack/sustain/release envelope and mixes all voices into one registered sample.
module poly_voice_controller #(
  parameter int NUM_VOICES = 4,
  parameter int AMP_W      = 6,
  parameter int FREQ_W     = 16,
  parameter int ENV_DIV    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  poly_voice_if.slave  bus
);
  localparam int VW    = $clog2(NUM_VOICES);
  localparam int SUM_W = AMP_W + VW;
  localparam int PW    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} voice_state_t;

  voice_state_t          state_q [NUM_VOICES];
  voice_state_t          state_d [NUM_VOICES];
  logic [AMP_W-1:0]      env_q   [NUM_VOICES];
  logic [AMP_W-1:0]      env_d   [NUM_VOICES];
  logic [AMP_W-1:0]      peak_q  [NUM_VOICES];
  logic [AMP_W-1:0]      peak_d  [NUM_VOICES];
  logic [FREQ_W-1:0]     phase_q [NUM_VOICES];
  logic [FREQ_W-1:0]     phase_d [NUM_VOICES];
  logic [FREQ_W-1:0]     hp_q    [NUM_VOICES];
  logic [FREQ_W-1:0]     hp_d    [NUM_VOICES];
  logic [6:0]            key_q   [NUM_VOICES];
  logic [6:0]            key_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] sq_q, sq_d;
  logic [VW-1:0]         steal_ptr_q, steal_ptr_d;
  logic [PW-1:0]         presc_q;
  logic                  tick;

  logic [NUM_VOICES-1:0] match_on;
  logic                  have_idle;
  logic [VW-1:0]         first_idle;
  logic [VW-1:0]         target;
  logic [AMP_W:0]        env_sum;
  logic [SUM_W-1:0]      mix_sum;
  logic [SUM_W:0]        mix_scaled;
  logic [AMP_W:0]        wave_q;
  logic [NUM_VOICES-1:0] active;

  assign tick = (presc_q == PW'(ENV_DIV - 1));

  // Shared envelope prescaler, free-running from reset.
  always_ff @(posedge clk) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    match_on    = '0;
    have_idle   = 1'b0;
    first_idle  = '0;
    target      = '0;
    env_sum     = '0;
    steal_ptr_d = steal_ptr_q;
    sq_d        = sq_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_d[i] = state_q[i];
      env_d[i]   = env_q[i];
      peak_d[i]  = peak_q[i];
      phase_d[i] = phase_q[i];
      hp_d[i]    = hp_q[i];
      key_d[i]   = key_q[i];
      match_on[i] = (state_q[i] != IDLE) && (key_q[i] == bus.key);
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (state_q[i] == IDLE) begin
        have_idle  = 1'b1;
        first_idle = VW'(i);
      end
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (state_q[i] != IDLE) begin
        if (hp_q[i] == '0) begin
          phase_d[i] = '0;
          sq_d[i]    = 1'b0;
        end else if (phase_q[i] == hp_q[i] - FREQ_W'(1)) begin
          phase_d[i] = '0;
          sq_d[i]    = ~sq_q[i];
        end else begin
          phase_d[i] = phase_q[i] + FREQ_W'(1);
        end
      end

      if (tick) begin
        case (state_q[i])
          ATTACK: begin
            env_sum = {1'b0, env_q[i]} + {1'b0, bus.attack};
            if (bus.attack == '0 || env_sum >= {1'b0, peak_q[i]}) begin
              env_d[i]   = peak_q[i];
              state_d[i] = SUSTAIN;
            end else begin
              env_d[i] = env_sum[AMP_W-1:0];
            end
          end
          RELEASE: begin
            if (bus.rel == '0 || env_q[i] <= bus.rel) begin
              env_d[i]   = '0;
              state_d[i] = IDLE;
              phase_d[i] = '0;
              sq_d[i]    = 1'b0;
            end else begin
              env_d[i] = env_q[i] - bus.rel;
            end
          end
          default: ;
        endcase
      end

      // A simultaneous note_on takes precedence, so release only fires alone.
      if (bus.note_off && !bus.note_on && key_q[i] == bus.key &&
          (state_q[i] == ATTACK || state_q[i] == SUSTAIN)) begin
        state_d[i] = RELEASE;
        env_d[i]   = env_q[i];
      end
    end

    if (bus.note_on) begin
      if (match_on != '0) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (match_on[i]) begin
            state_d[i] = ATTACK;
            env_d[i]   = env_q[i];
            peak_d[i]  = bus.amplitude;
          end
        end
      end else begin
        target = have_idle ? first_idle : steal_ptr_q;
        if (!have_idle) steal_ptr_d = steal_ptr_q + VW'(1);
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (VW'(i) == target) begin
            state_d[i] = ATTACK;
            env_d[i]   = '0;
            peak_d[i]  = bus.amplitude;
            key_d[i]   = bus.key;
            hp_d[i]    = bus.half_period;
            phase_d[i] = '0;
            sq_d[i]    = 1'b0;
          end
        end
      end
    end
  end

  // Mix: sum gated envelopes, then scale by 2/NUM_VOICES so a full chord fits AMP_W+1 bits.
  always_comb begin
    mix_sum = '0;
    active  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (sq_q[i]) mix_sum = mix_sum + SUM_W'(env_q[i]);
      active[i] = (state_q[i] != IDLE);
    end
    mix_scaled = {mix_sum, 1'b0} >> VW;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= IDLE;
        env_q[i]   <= '0;
        peak_q[i]  <= '0;
        phase_q[i] <= '0;
        hp_q[i]    <= '0;
        key_q[i]   <= '0;
      end
      sq_q        <= '0;
      steal_ptr_q <= '0;
      wave_q      <= '0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      peak_q      <= peak_d;
      phase_q     <= phase_d;
      hp_q        <= hp_d;
      key_q       <= key_d;
      sq_q        <= sq_d;
      steal_ptr_q <= steal_ptr_d;
      wave_q      <= mix_scaled[AMP_W:0];
    end
  end

  assign bus.voices_active = active;
  assign bus.wave_out      = wave_q;
endmodule

// File: tb/tb_poly_voice_controller.sv
// Directed bench for poly_voice_controller: a vector table for the main note flow,
// plus hand sequences for retrigger, simultaneous events, attack=0 and reset mid-release.
module tb_poly_voice_controller;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  poly_voice_if #(.NUM_VOICES(4), .AMP_W(6), .FREQ_W(16)) bus ();

  poly_voice_controller #(
    .NUM_VOICES(4),
    .AMP_W(6),
    .FREQ_W(16),
    .ENV_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       on;
    logic       off;
    logic [6:0] key;
    logic [15:0] hp;
    int         n;
    logic [3:0] exp_active;
    logic [6:0] exp_wave;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic on, input logic off, input logic [6:0] key,
                         input logic [15:0] hp, input int n,
                         input logic [3:0] exp_active, input logic [6:0] exp_wave);
    vec_t v;
    v.on = on; v.off = off; v.key = key; v.hp = hp; v.n = n;
    v.exp_active = exp_active; v.exp_wave = exp_wave;
    vecs.push_back(v);
  endtask

  // Drive one event on the next edge, then idle for the rest of n edges; sample #1 after the last.
  task automatic applyStimulus(input logic on, input logic off, input logic [6:0] key,
                               input logic [15:0] hp, input logic [5:0] amp,
                               input logic [5:0] atk, input logic [5:0] rel, input int n);
    bus.note_on     = on;
    bus.note_off    = off;
    bus.key         = key;
    bus.half_period = hp;
    bus.amplitude   = amp;
    bus.attack      = atk;
    bus.rel         = rel;
    @(posedge clk);
    #1;
    bus.note_on  = 1'b0;
    bus.note_off = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_active,
                             input logic [6:0] exp_wave);
    total_cnt++;
    if (bus.voices_active === exp_active) pass_cnt++;
    else $display("[TB] FAIL %s voices_active: got %b, expected %b", name, bus.voices_active, exp_active);
    total_cnt++;
    if (bus.wave_out === exp_wave) pass_cnt++;
    else $display("[TB] FAIL %s wave_out: got %0d, expected %0d", name, bus.wave_out, exp_wave);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(name, 4'b0000, 7'd0);
    reset = 1'b1;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b0;
    bus.note_on = 1'b0;
    bus.note_off = 1'b0;
    bus.key = '0;
    bus.half_period = '0;
    bus.amplitude = '0;
    bus.attack = '0;
    bus.rel = '0;

    // Edge numbers count from the first edge after reset; ticks land on multiples of 4.
    add_vec(1, 0, 7'h45, 16'd3, 1, 4'b0001, 7'd0);
    add_vec(0, 0, 7'h45, 16'd3, 5, 4'b0001, 7'd4);
    add_vec(0, 0, 7'h45, 16'd3, 3, 4'b0001, 7'd0);
    add_vec(0, 0, 7'h45, 16'd3, 2, 4'b0001, 7'd8);
    add_vec(0, 0, 7'h45, 16'd3, 6, 4'b0001, 7'd16);
    add_vec(0, 0, 7'h45, 16'd3, 3, 4'b0001, 7'd0);
    add_vec(0, 0, 7'h45, 16'd3, 3, 4'b0001, 7'd16);
    add_vec(0, 1, 7'h45, 16'd3, 1, 4'b0001, 7'd16);
    add_vec(0, 0, 7'h45, 16'd3, 5, 4'b0001, 7'd12);
    add_vec(0, 0, 7'h45, 16'd3, 6, 4'b0001, 7'd8);
    add_vec(0, 0, 7'h45, 16'd3, 2, 4'b0001, 7'd4);
    add_vec(0, 0, 7'h45, 16'd3, 3, 4'b0000, 7'd0);
    add_vec(0, 0, 7'h45, 16'd3, 1, 4'b0000, 7'd0);
    add_vec(1, 0, 7'h40, 16'd0, 1, 4'b0001, 7'd0);
    add_vec(1, 0, 7'h41, 16'd0, 1, 4'b0011, 7'd0);
    add_vec(1, 0, 7'h42, 16'd0, 1, 4'b0111, 7'd0);
    add_vec(1, 0, 7'h43, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(1, 0, 7'h44, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 1, 7'h40, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 1, 7'h44, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 0, 7'h44, 16'd0, 4, 4'b1110, 7'd0);
    add_vec(1, 0, 7'h46, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(1, 0, 7'h47, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 1, 7'h41, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 1, 7'h47, 16'd0, 1, 4'b1111, 7'd0);
    add_vec(0, 0, 7'h47, 16'd0, 4, 4'b1101, 7'd0);

    do_reset("reset_initial");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].on, vecs[i].off, vecs[i].key, vecs[i].hp,
                    6'd32, 6'd8, 6'd8, vecs[i].n);
      checkOutput($sformatf("row%0d", i), vecs[i].exp_active, vecs[i].exp_wave);
    end

    // Retrigger: half_period=1 toggles sq every edge, peak raised from 20 to 40.
    do_reset("reset_mid_note");
    applyStimulus(1, 0, 7'h45, 16'd1, 6'd20, 6'd8, 6'd8, 1);
    checkOutput("retrig_alloc", 4'b0001, 7'd0);
    applyStimulus(0, 0, 7'h45, 16'd1, 6'd20, 6'd8, 6'd8, 11);
    checkOutput("retrig_sustain20", 4'b0001, 7'd0);
    applyStimulus(1, 0, 7'h45, 16'd1, 6'd40, 6'd8, 6'd8, 1);
    checkOutput("retrig_event", 4'b0001, 7'd10);
    applyStimulus(0, 0, 7'h45, 16'd1, 6'd40, 6'd8, 6'd8, 2);
    checkOutput("retrig_keep_env", 4'b0001, 7'd10);
    applyStimulus(0, 0, 7'h45, 16'd1, 6'd40, 6'd8, 6'd8, 2);
    checkOutput("retrig_env28", 4'b0001, 7'd14);
    applyStimulus(0, 0, 7'h45, 16'd1, 6'd40, 6'd8, 6'd8, 4);
    checkOutput("retrig_env36", 4'b0001, 7'd18);
    applyStimulus(0, 0, 7'h45, 16'd1, 6'd40, 6'd8, 6'd8, 4);
    checkOutput("retrig_env40", 4'b0001, 7'd20);

    // Simultaneous on/off, attack=0, unmatched note_off, then reset during release.
    do_reset("reset_seq3");
    applyStimulus(1, 1, 7'h30, 16'd1, 6'd30, 6'd0, 6'd8, 1);
    checkOutput("onoff_same_cycle", 4'b0001, 7'd0);
    applyStimulus(0, 0, 7'h30, 16'd1, 6'd30, 6'd0, 6'd8, 3);
    checkOutput("attack0_before_tick", 4'b0001, 7'd0);
    applyStimulus(0, 0, 7'h30, 16'd1, 6'd30, 6'd0, 6'd8, 1);
    checkOutput("attack0_after_tick", 4'b0001, 7'd15);
    applyStimulus(0, 1, 7'h31, 16'd1, 6'd30, 6'd0, 6'd8, 2);
    checkOutput("off_unmatched", 4'b0001, 7'd15);
    applyStimulus(0, 1, 7'h30, 16'd1, 6'd30, 6'd0, 6'd8, 2);
    checkOutput("release_start", 4'b0001, 7'd15);
    applyStimulus(0, 0, 7'h30, 16'd1, 6'd30, 6'd0, 6'd8, 1);
    checkOutput("release_hold", 4'b0001, 7'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_release", 4'b0000, 7'd0);
    reset = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
